// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and counter constants for the branch predictor
package branch_predictor_pkg;

    typedef logic [31:0] word_t;

    localparam int DEF_ENTRIES  = 16;
    localparam int DEF_CTR_BITS = 2;

    function automatic logic [31:0] sat_max(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] weak_taken(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - next-value logic for a saturating up/down counter with load
module sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] nxt
);

    localparam logic [W-1:0] MAX = W'(sat_max(W));

    always_comb begin
        nxt = cnt;
        if (load) begin
            nxt = load_val;
        end else if (inc && cnt != MAX) begin
            nxt = cnt + 1'b1;
        end else if (dec && cnt != '0) begin
            nxt = cnt - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped tagged predictor with saturating counters and statistics
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES  = DEF_ENTRIES,
    parameter int CTR_BITS = DEF_CTR_BITS
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en,
    input  logic  flush,
    input  word_t lookup_pc,
    output logic  pred_taken,
    output word_t pred_target,
    input  logic  upd_valid,
    input  word_t upd_pc,
    input  logic  upd_taken,
    input  word_t upd_target,
    input  logic  upd_pred,
    output word_t br_count,
    output word_t miss_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(weak_taken(CTR_BITS));

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    word_t               target_q [ENTRIES];
    word_t               br_cnt_q;
    word_t               miss_cnt_q;

    logic [IDX-1:0]      l_idx, u_idx;
    logic [TAG_W-1:0]    l_tag, u_tag;
    logic                l_hit, u_hit, accept;
    logic [CTR_BITS-1:0] ctr_nxt;
    word_t               br_nxt, miss_nxt;

    assign l_idx = lookup_pc[IDX+1:2];
    assign l_tag = lookup_pc[31:IDX+2];
    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[31:IDX+2];

    assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign pred_taken  = l_hit && ctr_q[l_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? target_q[l_idx] : lookup_pc + 32'd4;
    assign accept      = upd_valid && en && !flush;

    // A taken miss loads the weakly-taken value, so allocation shares the update path.
    sat_counter #(.W(CTR_BITS)) u_entry_ctr (
        .cnt      (ctr_q[u_idx]),
        .inc      (u_hit && upd_taken),
        .dec      (u_hit && !upd_taken),
        .load     (!u_hit && upd_taken),
        .load_val (WEAK),
        .nxt      (ctr_nxt)
    );

    sat_counter #(.W(32)) u_br_ctr (
        .cnt      (br_cnt_q),
        .inc      (accept),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .nxt      (br_nxt)
    );

    sat_counter #(.W(32)) u_miss_ctr (
        .cnt      (miss_cnt_q),
        .inc      (accept && (upd_pred != upd_taken)),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .nxt      (miss_nxt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= '0;
                target_q[i] <= '0;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (en) begin
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (upd_valid) begin
                br_cnt_q   <= br_nxt;
                miss_cnt_q <= miss_nxt;
                if (u_hit || upd_taken) begin
                    ctr_q[u_idx] <= ctr_nxt;
                end
                if (upd_taken) begin
                    target_q[u_idx] <= upd_target;
                end
                if (!u_hit && upd_taken) begin
                    valid_q[u_idx] <= 1'b1;
                    tag_q[u_idx]   <= u_tag;
                end
            end
        end
    end

    assign br_count   = br_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST, en, flush, upd_valid, upd_taken, upd_pred;
    logic  pred_taken;
    word_t lookup_pc, pred_target, upd_pc, upd_target, br_count, miss_count;
    int    n_assert = 0;
    int    n_fail   = 0;

    branch_predictor dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .en          (en),
        .flush       (flush),
        .lookup_pc   (lookup_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_pred    (upd_pred),
        .br_count    (br_count),
        .miss_count  (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic update(input word_t pc, input logic tk, input word_t tgt, input logic pr);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_pred   = pr;
        step();
        upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input word_t pc, input logic exp_t, input word_t exp_tgt);
        lookup_pc = pc;
        #1;
        check({tag, "_taken"}, 32'(pred_taken), 32'(exp_t));
        check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    initial begin
        nRST = 1'b0; en = 1'b0; flush = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b0;
        lookup_pc = 32'h40;
        #3;
        look("reset", 32'h40, 1'b0, 32'h44);
        check("reset_br", br_count, 32'd0);
        check("reset_miss", miss_count, 32'd0);
        #4 nRST = 1'b1;
        en = 1'b1;
        step();

        update(32'h40, 1'b1, 32'h100, 1'b0);
        look("alloc", 32'h40, 1'b1, 32'h100);
        check("alloc_ctr", 32'(dut.ctr_q[0]), 32'd2);
        check("alloc_miss", miss_count, 32'd1);
        check("alloc_br", br_count, 32'd1);

        for (int i = 0; i < 3; i++) update(32'h40, 1'b1, 32'h100, 1'b1);
        check("sat_ctr", 32'(dut.ctr_q[0]), 32'd3);
        update(32'h40, 1'b0, 32'h0, 1'b1);
        update(32'h40, 1'b0, 32'h0, 1'b1);
        check("dec_ctr", 32'(dut.ctr_q[0]), 32'd1);
        look("dec", 32'h40, 1'b0, 32'h44);
        check("dec_miss", miss_count, 32'd3);
        check("dec_br", br_count, 32'd6);

        en = 1'b0;
        update(32'h40, 1'b1, 32'h500, 1'b0);
        en = 1'b1;
        check("hold_ctr", 32'(dut.ctr_q[0]), 32'd1);
        check("hold_br", br_count, 32'd6);

        update(32'h80, 1'b1, 32'h200, 1'b0);
        look("alias_old", 32'h40, 1'b0, 32'h44);
        look("alias_new", 32'h80, 1'b1, 32'h200);
        check("alias_miss", miss_count, 32'd4);

        update(32'hC0, 1'b0, 32'h0, 1'b0);
        look("nt_miss", 32'h80, 1'b1, 32'h200);
        check("nt_br", br_count, 32'd8);
        check("nt_miss_cnt", miss_count, 32'd4);

        lookup_pc  = 32'h40;
        upd_valid  = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        upd_target = 32'h300; upd_pred = 1'b0;
        #1;
        check("same_cycle_pre", 32'(pred_taken), 32'd0);
        step();
        upd_valid = 1'b0;
        look("same_cycle_post", 32'h40, 1'b1, 32'h300);

        flush = 1'b1;
        update(32'h44, 1'b1, 32'h600, 1'b0);
        flush = 1'b0;
        look("flush_a", 32'h40, 1'b0, 32'h44);
        look("flush_b", 32'h44, 1'b0, 32'h48);
        check("flush_br", br_count, 32'd9);
        check("flush_miss", miss_count, 32'd5);

        update(32'h40, 1'b1, 32'h700, 1'b1);
        en = 1'b0; flush = 1'b1;
        step();
        en = 1'b1; flush = 1'b0;
        look("flush_noen", 32'h40, 1'b1, 32'h700);

        force dut.br_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.br_cnt_q;
        update(32'h40, 1'b1, 32'h700, 1'b1);
        check("br_sat1", br_count, 32'hFFFF_FFFF);
        update(32'h40, 1'b1, 32'h700, 1'b1);
        check("br_sat2", br_count, 32'hFFFF_FFFF);

        upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_pred = 1'b0;
        #2 nRST = 1'b0;
        #1;
        look("async_rst", 32'h40, 1'b0, 32'h44);
        check("async_br", br_count, 32'd0);
        check("async_miss", miss_count, 32'd0);
        check("async_ctr", 32'(dut.ctr_q[0]), 32'd0);
        upd_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, SHALL set the number of table entries; it must be a power of two, 4..256.
REQ-002 Parameter CTR_BITS, default 2, SHALL set the saturating-counter width, 1..4.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 nRST  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 en  input  1  pipeline advance (ihit-qualified); gates all state updates.
REQ-006 flush  input  1  invalidate the whole table.
REQ-007 lookup_pc  input  32  fetch PC.
REQ-008 pred_taken  output  1  prediction for lookup_pc.
REQ-009 pred_target  output  32  predicted next PC.
REQ-010 upd_valid  input  1  a resolved branch is presented.
REQ-011 upd_pc  input  32  resolved branch PC.
REQ-012 upd_taken  input  1  actual outcome.
REQ-013 upd_target  input  32  actual taken target.
REQ-014 upd_pred  input  1  prediction originally made for that branch.
REQ-015 br_count  output  32  accepted updates.
REQ-016 miss_count  output  32  mispredictions.

Function
REQ-017 IDX = log2(ENTRIES) SHALL be the index width; index = pc[IDX+1:2]; tag = pc[31:IDX+2].
REQ-018 Each entry SHALL hold valid, tag, CTR_BITS counter and 32-bit target.
REQ-019 Lookup SHALL be combinational, zero latency: hit = valid[idx] and tag match.
REQ-020 pred_taken SHALL equal hit AND counter MSB.
REQ-021 pred_target SHALL be the stored target when pred_taken=1, else lookup_pc+4 (mod 2^32).
REQ-022 An update SHALL be accepted on a rising edge only when upd_valid=1, en=1 and flush=0.
REQ-023 On an accepted update with an upd_pc hit, the counter SHALL increment when taken and decrement when not-taken, saturating at 2^CTR_BITS-1 and 0; the target SHALL be overwritten only when taken.
REQ-024 On an accepted update with a miss and upd_taken=1, the entry SHALL be allocated (replacing any occupant): valid=1, new tag, target=upd_target, counter=2^(CTR_BITS-1) (weakly taken).
REQ-025 On an accepted update with a miss and upd_taken=0, no table state SHALL change.
REQ-026 Lookup and update to the same index in one cycle: lookup SHALL return pre-update state (no bypass).
REQ-027 flush=1 with en=1 SHALL clear every valid bit on that edge; flush overrides any simultaneous update; flush with en=0 SHALL be ignored.
REQ-028 br_count SHALL increment by 1 per accepted update, saturating at 32'hFFFFFFFF.
REQ-029 miss_count SHALL increment by 1 per accepted update where upd_pred != upd_taken, saturating at 32'hFFFFFFFF.
REQ-030 With en=0 no state (table or statistics) SHALL change; outputs still track lookup_pc.

Reset
REQ-031 nRST low SHALL immediately clear all valid bits, counters, targets, tags, br_count and miss_count to 0, regardless of CLK or in-flight updates.
REQ-032 After reset every lookup SHALL yield pred_taken=0, pred_target=lookup_pc+4.

Structure
REQ-033 A shared package SHALL hold word_t (32-bit), the default ENTRIES and CTR_BITS values, and the weakly-taken/saturation constants as functions of CTR_BITS.
REQ-034 One sub-module, sat_counter (parametrised width, inc/dec/load inputs), SHALL implement the counter update and SHALL be reused for both the per-entry update logic and the statistics counters.

Verification
REQ-035 Reset, lookup_pc=0x00000040 -> pred_taken=0, pred_target=0x00000044, br_count=0, miss_count=0.
REQ-036 Update pc=0x40 taken target=0x100 upd_pred=0, then lookup 0x40 -> pred_taken=1, pred_target=0x100, counter=2, miss_count=1.
REQ-037 Three more taken updates to 0x40 -> counter saturates at 3; then two not-taken -> counter=1, pred_taken=0, pred_target=0x44.
REQ-038 ENTRIES=16: allocate 0x40, then taken update pc=0x80 (same index, different tag) -> lookup 0x40 misses, lookup 0x80 hits with new target.
REQ-039 Same-cycle lookup and allocating update on 0x40 -> lookup returns pred_taken=0 that cycle, 1 the next; flush with en=1 plus simultaneous update -> all lookups miss afterwards, br_count unchanged.
REQ-040 Preload br_count to 32'hFFFFFFFE (force), two accepted updates -> holds 32'hFFFFFFFF; assert nRST mid-sequence -> all outputs return to REQ-035 values without a clock edge.
